// File: rtl/pci_arbiter.sv
// Round-robin central arbiter for the shared PCI-style bus. It issues one
// registered active-low grant at a time and inserts a turnaround cycle after each transaction.
module pci_arbiter #(
  parameter int unsigned NUM_DEV     = 4,
  parameter int unsigned IDW         = 2,
  parameter int unsigned GNT_TIMEOUT = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_DEV-1:0] REQ_N,
  input  logic               FRAME_N,
  input  logic               IRDY_N,
  output logic [NUM_DEV-1:0] GNT_N,
  output logic [IDW-1:0]     OWNER,
  output logic               BUS_BUSY,
  output logic               TIMEOUT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_BUSY,
    S_TURN
  } state_e;

  state_e             state_q;
  logic [NUM_DEV-1:0] gnt_n_q;
  logic [IDW-1:0]     owner_q;
  logic [IDW-1:0]     ptr_q;
  logic               busy_q;
  logic               timeout_q;
  logic [7:0]         cnt_q;

  logic               bus_idle;
  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic [IDW-1:0]     ptr_adv_d;

  assign bus_idle = FRAME_N & IRDY_N;

  // Search order starts at ptr_q and wraps, so the first hit is the round-robin winner.
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NUM_DEV)) begin
        sum = sum - (IDW+1)'(NUM_DEV);
      end
      idx = sum[IDW-1:0];
      if (!win_found && !REQ_N[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign ptr_adv_d = (owner_q == IDW'(NUM_DEV - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      gnt_n_q   <= '1;
      owner_q   <= '0;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_found && bus_idle) begin
            state_q <= S_GRANT;
            gnt_n_q <= ~(NUM_DEV'(1) << win_idx);
            owner_q <= win_idx;
            cnt_q   <= '0;
          end
        end
        S_GRANT: begin
          cnt_q <= cnt_q + 8'd1;
          // FRAME# beats both withdrawal and timeout when they coincide.
          if (!FRAME_N) begin
            state_q <= S_BUSY;
            gnt_n_q <= '1;
            busy_q  <= 1'b1;
            ptr_q   <= ptr_adv_d;
          end else if (REQ_N[owner_q]) begin
            state_q <= S_IDLE;
            gnt_n_q <= '1;
          end else if (cnt_q == 8'(GNT_TIMEOUT - 1)) begin
            state_q   <= S_IDLE;
            gnt_n_q   <= '1;
            timeout_q <= 1'b1;
            ptr_q     <= ptr_adv_d;
          end
        end
        S_BUSY: begin
          if (bus_idle) begin
            state_q <= S_TURN;
            busy_q  <= 1'b0;
          end
        end
        S_TURN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          gnt_n_q <= '1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign GNT_N    = gnt_n_q;
  assign OWNER    = owner_q;
  assign BUS_BUSY = busy_q;
  assign TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Scoreboard bench for pci_arbiter: expected grantees are queued as requests are
// driven and popped when a grant appears.
module tb_pci_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] REQ_N;
  logic       FRAME_N;
  logic       IRDY_N;
  logic [3:0] GNT_N;
  logic [1:0] OWNER;
  logic       BUS_BUSY;
  logic       TIMEOUT;

  int checks   = 0;
  int failures = 0;
  int sb[$];

  always #5 CLK = ~CLK;

  pci_arbiter #(
    .NUM_DEV(4),
    .IDW(2),
    .GNT_TIMEOUT(16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .REQ_N(REQ_N),
    .FRAME_N(FRAME_N),
    .IRDY_N(IRDY_N),
    .GNT_N(GNT_N),
    .OWNER(OWNER),
    .BUS_BUSY(BUS_BUSY),
    .TIMEOUT(TIMEOUT)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST = 1'b1; REQ_N = 4'b1111; FRAME_N = 1'b1; IRDY_N = 1'b1;
    step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ_N = 4'b1111; FRAME_N = 1'b1; IRDY_N = 1'b1;
    step(); step();
    checks++; if (GNT_N !== 4'b1111) begin failures++; $display("FAIL reset_gnt got=%b exp=1111", GNT_N); end
    checks++; if (OWNER !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", OWNER); end
    checks++; if (BUS_BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUS_BUSY); end
    checks++; if (TIMEOUT !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", TIMEOUT); end
    RST = 1'b0;
  endtask

  task automatic test_basic();
    int e; logic [3:0] eg;
    REQ_N = 4'b1110; sb.push_back(0);
    step();
    e = sb.pop_front(); eg = ~(4'b0001 << e);
    checks++; if (GNT_N !== eg) begin failures++; $display("FAIL basic_gnt got=%b exp=%b", GNT_N, eg); end
    checks++; if (OWNER !== e[1:0]) begin failures++; $display("FAIL basic_owner got=%0d exp=%0d", OWNER, e); end
    FRAME_N = 1'b0; REQ_N = 4'b1111;
    step();
    checks++; if (GNT_N !== 4'b1111) begin failures++; $display("FAIL basic_release got=%b exp=1111", GNT_N); end
    checks++; if (BUS_BUSY !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", BUS_BUSY); end
    IRDY_N = 1'b0;
    step(); step();
    FRAME_N = 1'b1; IRDY_N = 1'b1;
    checks++; if (BUS_BUSY !== 1'b1) begin failures++; $display("FAIL basic_busy_hold got=%b exp=1", BUS_BUSY); end
    step();
    checks++; if (BUS_BUSY !== 1'b0) begin failures++; $display("FAIL basic_turn_busy got=%b exp=0", BUS_BUSY); end
    checks++; if (GNT_N !== 4'b1111) begin failures++; $display("FAIL basic_turn_gnt got=%b exp=1111", GNT_N); end
    step();
  endtask

  task automatic test_round_robin();
    int e, gap, waited; logic [3:0] eg;
    apply_reset();
    REQ_N = 4'b0000;
    sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3); sb.push_back(0);
    for (int t = 0; t < 5; t++) begin
      gap = 0; waited = 0;
      step();
      while (GNT_N === 4'b1111 && waited < 10) begin gap++; waited++; step(); end
      checks++;
      if (GNT_N === 4'b1111) begin
        failures++; $display("FAIL rr_wait got=no_grant exp=grant t=%0d", t);
      end else begin
        e = sb.pop_front(); eg = ~(4'b0001 << e);
        checks++; if (GNT_N !== eg) begin failures++; $display("FAIL rr_gnt got=%b exp=%b t=%0d", GNT_N, eg, t); end
        checks++; if (OWNER !== e[1:0]) begin failures++; $display("FAIL rr_owner got=%0d exp=%0d t=%0d", OWNER, e, t); end
        if (t > 0) begin
          checks++; if (gap < 1) begin failures++; $display("FAIL rr_gap got=%0d exp>=1 t=%0d", gap, t); end
        end
      end
      FRAME_N = 1'b0;
      if (t == 4) REQ_N = 4'b1111;
      step(); step();
      FRAME_N = 1'b1;
    end
    step(); step(); step();
    checks++; if (GNT_N !== 4'b1111) begin failures++; $display("FAIL rr_end got=%b exp=1111", GNT_N); end
  endtask

  task automatic test_timeout();
    int e, cnt; logic [3:0] eg;
    apply_reset();
    REQ_N = 4'b1011; sb.push_back(2);
    step();
    e = sb.pop_front(); eg = ~(4'b0001 << e);
    checks++; if (GNT_N !== eg) begin failures++; $display("FAIL to_gnt got=%b exp=%b", GNT_N, eg); end
    cnt = 0;
    while (GNT_N === eg && cnt < 40) begin cnt++; step(); end
    checks++; if (cnt !== 16) begin failures++; $display("FAIL to_len got=%0d exp=16", cnt); end
    checks++; if (TIMEOUT !== 1'b1) begin failures++; $display("FAIL to_pulse got=%b exp=1", TIMEOUT); end
    checks++; if (GNT_N !== 4'b1111) begin failures++; $display("FAIL to_revoke got=%b exp=1111", GNT_N); end
    REQ_N = 4'b1001; sb.push_back(1);
    step();
    checks++; if (TIMEOUT !== 1'b0) begin failures++; $display("FAIL to_pulse_end got=%b exp=0", TIMEOUT); end
    e = sb.pop_front(); eg = ~(4'b0001 << e);
    checks++; if (GNT_N !== eg) begin failures++; $display("FAIL to_next_gnt got=%b exp=%b", GNT_N, eg); end
    checks++; if (OWNER !== e[1:0]) begin failures++; $display("FAIL to_next_owner got=%0d exp=%0d", OWNER, e); end
    REQ_N = 4'b1011; sb.push_back(2);
    step();
    checks++; if (GNT_N !== 4'b1111) begin failures++; $display("FAIL to_wd_gnt got=%b exp=1111", GNT_N); end
    step();
    e = sb.pop_front(); eg = ~(4'b0001 << e);
    checks++; if (GNT_N !== eg) begin failures++; $display("FAIL to_regrant got=%b exp=%b", GNT_N, eg); end
    REQ_N = 4'b1111;
    step(); step();
  endtask

  task automatic test_withdrawal();
    int e; logic [3:0] eg;
    apply_reset();
    REQ_N = 4'b1011; sb.push_back(2);
    step();
    e = sb.pop_front(); eg = ~(4'b0001 << e);
    checks++; if (GNT_N !== eg) begin failures++; $display("FAIL wd_pre_gnt got=%b exp=%b", GNT_N, eg); end
    FRAME_N = 1'b0; REQ_N = 4'b1111;
    step();
    FRAME_N = 1'b1;
    step(); step();
    REQ_N = 4'b0111; sb.push_back(3);
    step();
    e = sb.pop_front(); eg = ~(4'b0001 << e);
    checks++; if (GNT_N !== eg) begin failures++; $display("FAIL wd_gnt got=%b exp=%b", GNT_N, eg); end
    step(); step();
    checks++; if (GNT_N !== eg) begin failures++; $display("FAIL wd_hold got=%b exp=%b", GNT_N, eg); end
    REQ_N = 4'b1111;
    step();
    checks++; if (GNT_N !== 4'b1111) begin failures++; $display("FAIL wd_release got=%b exp=1111", GNT_N); end
    checks++; if (TIMEOUT !== 1'b0) begin failures++; $display("FAIL wd_timeout got=%b exp=0", TIMEOUT); end
    REQ_N = 4'b0000; sb.push_back(3);
    step();
    e = sb.pop_front(); eg = ~(4'b0001 << e);
    checks++; if (GNT_N !== eg) begin failures++; $display("FAIL wd_prio got=%b exp=%b", GNT_N, eg); end
    checks++; if (OWNER !== e[1:0]) begin failures++; $display("FAIL wd_prio_owner got=%0d exp=%0d", OWNER, e); end
    REQ_N = 4'b1111;
    step(); step();
  endtask

  task automatic test_simultaneous();
    int e; logic [3:0] eg;
    apply_reset();
    REQ_N = 4'b1110; sb.push_back(0);
    step();
    e = sb.pop_front();
    checks++; if (OWNER !== e[1:0]) begin failures++; $display("FAIL sim_owner got=%0d exp=%0d", OWNER, e); end
    FRAME_N = 1'b0; REQ_N = 4'b1111;
    step();
    checks++; if (BUS_BUSY !== 1'b1) begin failures++; $display("FAIL sim_wd_busy got=%b exp=1", BUS_BUSY); end
    FRAME_N = 1'b1;
    step(); step();
    REQ_N = 4'b1101; sb.push_back(1);
    step();
    e = sb.pop_front(); eg = ~(4'b0001 << e);
    checks++; if (GNT_N !== eg) begin failures++; $display("FAIL sim_gnt got=%b exp=%b", GNT_N, eg); end
    for (int i = 0; i < 15; i++) step();
    FRAME_N = 1'b0;
    step();
    checks++; if (BUS_BUSY !== 1'b1) begin failures++; $display("FAIL sim_to_busy got=%b exp=1", BUS_BUSY); end
    checks++; if (TIMEOUT !== 1'b0) begin failures++; $display("FAIL sim_to_pulse got=%b exp=0", TIMEOUT); end
    FRAME_N = 1'b1; REQ_N = 4'b1111;
    step(); step();
  endtask

  task automatic test_reset_mid_busy();
    int e; logic [3:0] eg;
    apply_reset();
    REQ_N = 4'b1101; sb.push_back(1);
    step();
    e = sb.pop_front();
    checks++; if (OWNER !== e[1:0]) begin failures++; $display("FAIL rmb_owner got=%0d exp=%0d", OWNER, e); end
    FRAME_N = 1'b0;
    step();
    checks++; if (BUS_BUSY !== 1'b1) begin failures++; $display("FAIL rmb_busy got=%b exp=1", BUS_BUSY); end
    RST = 1'b1;
    step();
    RST = 1'b0;
    checks++; if (GNT_N !== 4'b1111) begin failures++; $display("FAIL rmb_gnt got=%b exp=1111", GNT_N); end
    checks++; if (OWNER !== 2'd0) begin failures++; $display("FAIL rmb_owner0 got=%0d exp=0", OWNER); end
    checks++; if (BUS_BUSY !== 1'b0) begin failures++; $display("FAIL rmb_busy0 got=%b exp=0", BUS_BUSY); end
    checks++; if (TIMEOUT !== 1'b0) begin failures++; $display("FAIL rmb_timeout got=%b exp=0", TIMEOUT); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (GNT_N !== 4'b1111) begin failures++; $display("FAIL rmb_nogrant got=%b exp=1111 i=%0d", GNT_N, i); end
    end
    FRAME_N = 1'b1; IRDY_N = 1'b0;
    step();
    checks++; if (GNT_N !== 4'b1111) begin failures++; $display("FAIL rmb_irdy got=%b exp=1111", GNT_N); end
    IRDY_N = 1'b1; sb.push_back(1);
    step();
    e = sb.pop_front(); eg = ~(4'b0001 << e);
    checks++; if (GNT_N !== eg) begin failures++; $display("FAIL rmb_regrant got=%b exp=%b", GNT_N, eg); end
    REQ_N = 4'b1111;
    step(); step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_withdrawal();
    test_simultaneous();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
